// File: rtl/spi_slave_gen.sv
// SPI slave front-end: deserialises {cmd, payload} frames from MOSI and serialises one RAM read word onto MISO.
// Optional aborted-frame/timeout error strobe on frame_err when SPI_FRAME_ERR_EN is defined.
module spi_slave_gen #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int BC_W    = $clog2(FRAME_W + 1);
    localparam int TO_W    = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);
    localparam logic [BC_W-1:0] TX_LAST = BC_W'(DATA_W);
    localparam logic [TO_W-1:0] TO_LAST = (TX_TIMEOUT > 0) ? TO_W'(TX_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT
    } state_t;

    state_t               state;
    logic [BC_W-1:0]      bitcount;
    logic [TO_W-1:0]      to_cnt;
    logic [FRAME_W-2:0]   shift_reg;
    logic [DATA_W-1:0]    tx_sr;
    logic                 rd_addr_seen;
    logic                 timeout_hit;

    always_comb begin
        timeout_hit = (TX_TIMEOUT != 0) && (state == TX_WAIT) && !tx_valid && (to_cnt == TO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            bitcount     <= '0;
            to_cnt       <= '0;
            shift_reg    <= '0;
            tx_sr        <= '0;
            rd_addr_seen <= 1'b0;
            MISO         <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
        end else begin
            rx_valid <= 1'b0;
            // Master releasing select mid-transaction wins over everything, including the final bit.
            if (state != IDLE && SS_n) begin
                state    <= IDLE;
                busy     <= 1'b0;
                bitcount <= '0;
                to_cnt   <= '0;
                MISO     <= 1'b0;
                if (state == TX_WAIT || state == TX_SHIFT)
                    rd_addr_seen <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!SS_n) begin
                            state    <= CHK_CMD;
                            busy     <= 1'b1;
                            bitcount <= '0;
                        end
                    end
                    CHK_CMD: begin
                        shift_reg <= {shift_reg[FRAME_W-3:0], MOSI};
                        bitcount  <= BC_W'(1);
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_addr_seen)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bitcount == BC_LAST) begin
                            rx_data  <= {shift_reg, MOSI};
                            rx_valid <= 1'b1;
                            bitcount <= '0;
                            if (state == READ_DATA) begin
                                state  <= TX_WAIT;
                                to_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (state == READ_ADD)
                                    rd_addr_seen <= 1'b1;
                            end
                        end else begin
                            shift_reg <= {shift_reg[FRAME_W-3:0], MOSI};
                            bitcount  <= bitcount + 1'b1;
                        end
                    end
                    TX_WAIT: begin
                        if (tx_valid) begin
                            // MSB goes out the cycle after the latch; the rest queue up in tx_sr.
                            MISO     <= tx_data[DATA_W-1];
                            tx_sr    <= tx_data << 1;
                            bitcount <= BC_W'(1);
                            to_cnt   <= '0;
                            state    <= TX_SHIFT;
                        end else if (timeout_hit) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            to_cnt       <= '0;
                            rd_addr_seen <= 1'b0;
                        end else if (to_cnt != '1) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    TX_SHIFT: begin
                        if (bitcount == TX_LAST) begin
                            MISO         <= 1'b0;
                            state        <= IDLE;
                            busy         <= 1'b0;
                            bitcount     <= '0;
                            rd_addr_seen <= 1'b0;
                        end else begin
                            MISO     <= tx_sr[DATA_W-1];
                            tx_sr    <= tx_sr << 1;
                            bitcount <= bitcount + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic err_evt;

    always_comb begin
        err_evt = 1'b0;
        if (SS_n) begin
            case (state)
                WRITE, READ_ADD, READ_DATA: err_evt = (bitcount != '0) && (bitcount <= BC_LAST);
                TX_WAIT, TX_SHIFT:          err_evt = 1'b1;
                default:                    err_evt = 1'b0;
            endcase
        end
        if (timeout_hit)
            err_evt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_err <= 1'b0;
        else
            frame_err <= err_evt;
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_gen.sv
// Scoreboarded bench for spi_slave_gen: an 8-bit instance (short timeout) and a 16-bit instance share clock and reset.
`timescale 1ns/1ps
module tb_spi_slave_gen;

`ifdef SPI_FRAME_ERR_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ss8, mosi8, miso8, txv8, rxv8, busy8, ferr8;
    logic [7:0]  txd8;
    logic [9:0]  rxd8;
    logic        ss16, mosi16, miso16, txv16, rxv16, busy16, ferr16;
    logic [15:0] txd16;
    logic [17:0] rxd16;

    spi_slave_gen #(.DATA_W(8), .TX_TIMEOUT(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss8), .MOSI(mosi8), .MISO(miso8),
        .tx_valid(txv8), .tx_data(txd8), .rx_valid(rxv8), .rx_data(rxd8),
        .busy(busy8), .frame_err(ferr8)
    );

    spi_slave_gen #(.DATA_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
        .tx_valid(txv16), .tx_data(txd16), .rx_valid(rxv16), .rx_data(rxd16),
        .busy(busy16), .frame_err(ferr16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int err8    = 0;
    int err16   = 0;
    logic [17:0] q8[$];
    logic [17:0] q16[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rx_valid strobe must match the oldest frame still owed.
    always @(negedge clk) begin
        if (rst_n && rxv8) begin
            if (q8.size() == 0) check("rx8_unexpected", 32'(rxv8), 32'd0);
            else                check("rx8_data", 32'(rxd8), 32'(q8.pop_front()));
        end
        if (rst_n && rxv16) begin
            if (q16.size() == 0) check("rx16_unexpected", 32'(rxv16), 32'd0);
            else                 check("rx16_data", 32'(rxd16), 32'(q16.pop_front()));
        end
        if (ferr8)  err8++;
        if (ferr16) err16++;
    end

    // Returns on the negedge just after the edge that sampled the last sent bit.
    task automatic send(input bit wide, input logic [17:0] frame, input int nbits, input bit keep_low);
        int fw;
        fw = wide ? 18 : 10;
        @(negedge clk);
        if (wide) ss16 = 1'b0; else ss8 = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            if (wide) mosi16 = frame[fw-1-b]; else mosi8 = frame[fw-1-b];
        end
        @(negedge clk);
        if (!keep_low) begin
            if (wide) begin ss16 = 1'b1; mosi16 = 1'b0; end
            else      begin ss8  = 1'b1; mosi8  = 1'b0; end
        end
    endtask

    task automatic tx_and_check(input bit wide, input logic [15:0] data, input int nbits);
        int dw;
        dw = wide ? 16 : 8;
        @(negedge clk);
        if (wide) begin txv16 = 1'b1; txd16 = data; end
        else      begin txv8  = 1'b1; txd8  = data[7:0]; end
        @(negedge clk);
        txv8  = 1'b0;
        txv16 = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("miso%0d_bit%0d", dw, k), wide ? 32'(miso16) : 32'(miso8), 32'(data[dw-1-k]));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst_n = 1'b0;
        ss8 = 1'b1; mosi8 = 1'b0; txv8 = 1'b0; txd8 = '0;
        ss16 = 1'b1; mosi16 = 1'b0; txv16 = 1'b0; txd16 = '0;
        repeat (3) @(negedge clk);
        check("rst_miso8", 32'(miso8), 0);
        check("rst_rxv8", 32'(rxv8), 0);
        check("rst_rxd8", 32'(rxd8), 0);
        check("rst_busy8", 32'(busy8), 0);
        check("rst_ferr8", 32'(ferr8), 0);
        check("rst_miso16", 32'(miso16), 0);
        check("rst_rxd16", 32'(rxd16), 0);
        check("rst_busy16", 32'(busy16), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write frame
        q8.push_back(18'h0A5);
        send(0, 18'h0A5, 10, 0);
        check("wr_miso", 32'(miso8), 0);
        check("wr_busy", 32'(busy8), 0);

        // Read address, then read data with RAM response
        q8.push_back(18'h230);
        send(0, 18'h230, 10, 0);
        check("ra_busy", 32'(busy8), 0);
        q8.push_back(18'h300);
        send(0, 18'h300, 10, 1);
        check("rd_in_txwait", 32'(busy8), 1);
        tx_and_check(0, 16'h00C3, 8);
        @(negedge clk);
        check("rd_done_busy", 32'(busy8), 0);
        check("rd_done_miso", 32'(miso8), 0);
        ss8 = 1'b1;
        check("rd_no_err", 32'(err8), 0);

        // rd_addr_seen cleared: a read-data command now routes to READ_ADD
        q8.push_back(18'h3FF);
        send(0, 18'h3FF, 10, 0);
        check("route_readadd_busy", 32'(busy8), 0);
        check("route_readadd_miso", 32'(miso8), 0);

        // Abort after 5 bits, then abort on the final-bit edge
        e0 = err8;
        send(0, 18'h0A5, 5, 0);
        repeat (2) @(negedge clk);
        check("abort5_err", 32'(err8 - e0), 32'(ERR_ON));
        check("abort5_busy", 32'(busy8), 0);
        e0 = err8;
        send(0, 18'h0A5, 9, 0);
        repeat (2) @(negedge clk);
        check("abort_last_err", 32'(err8 - e0), 32'(ERR_ON));
        check("abort_last_busy", 32'(busy8), 0);

        // Timeout: rd_addr_seen survived the aborts, so this frame waits for data
        e0 = err8;
        q8.push_back(18'h355);
        send(0, 18'h355, 10, 1);
        check("to_txwait", 32'(busy8), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d", i), 32'(busy8), 1);
        end
        @(negedge clk);
        check("to_idle", 32'(busy8), 0);
        ss8 = 1'b1;
        @(negedge clk);
        check("to_err", 32'(err8 - e0), 32'(ERR_ON));
        txv8 = 1'b1; txd8 = 8'hFF;
        @(negedge clk);
        txv8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("late_txv_miso%0d", i), 32'(miso8), 0);
            check($sformatf("late_txv_busy%0d", i), 32'(busy8), 0);
        end
        q8.push_back(18'h300);
        send(0, 18'h300, 10, 0);
        check("to_cleared_route", 32'(busy8), 0);

        // Reset during TX_SHIFT after 3 bits
        q8.push_back(18'h3C0);
        send(0, 18'h3C0, 10, 1);
        check("rst_case_txwait", 32'(busy8), 1);
        tx_and_check(0, 16'h00E7, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_miso", 32'(miso8), 0);
        check("midrst_busy", 32'(busy8), 0);
        check("midrst_rxv", 32'(rxv8), 0);
        @(negedge clk);
        ss8 = 1'b1;
        rst_n = 1'b1;
        q8.push_back(18'h3C3);
        send(0, 18'h3C3, 10, 0);
        check("midrst_route", 32'(busy8), 0);

        // 16-bit payload instance
        q16.push_back(18'h0BEEF);
        send(1, 18'h0BEEF, 18, 0);
        check("w16_busy", 32'(busy16), 0);
        check("w16_miso", 32'(miso16), 0);
        q16.push_back(18'h21234);
        send(1, 18'h21234, 18, 0);
        check("ra16_busy", 32'(busy16), 0);
        q16.push_back(18'h30000);
        send(1, 18'h30000, 18, 1);
        check("rd16_txwait", 32'(busy16), 1);
        tx_and_check(1, 16'hA5C3, 16);
        @(negedge clk);
        check("rd16_done_busy", 32'(busy16), 0);
        check("rd16_done_miso", 32'(miso16), 0);
        ss16 = 1'b1;

        repeat (2) @(negedge clk);
        check("q8_drained", 32'(q8.size()), 0);
        check("q16_drained", 32'(q16.size()), 0);
        check("err16_none", 32'(err16), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
